// File: rtl/mysoc_pkg.sv
// mysoc_pkg: shared encodings for the memory arbiter (FSM states, grant owner, transfer sizes).
package mysoc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} arbStateT;
    typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} gntT;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-like bus between fetch and data ports, data-priority with a
// starvation guard for fetch, one outstanding transaction at a time.
module mem_arbiter import mysoc_pkg::*; #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    arbStateT state, nextState;
    gntT gntSel, winner, sel;
    logic [2:0] starveCnt;
    logic starved, isData, accept, done;

    always_comb begin
        starved = inst_req && starveCnt == 3'(STARVE_MAX);
        winner = (data_req && !starved) ? GNT_DATA : GNT_INST;
        sel = (state == IDLE) ? winner : gntSel;
        isData = sel == GNT_DATA;
        // bus_req depends only on state and requests, never on the bus handshakes
        bus_req = !rst && (state == REQ || (state == IDLE && (inst_req || data_req)));
        bus_wr = bus_req && isData && data_wr;
        bus_size = !bus_req ? 2'd0 : isData ? data_size : SZ_WORD;
        bus_addr = !bus_req ? 32'd0 : isData ? data_addr : inst_addr;
        bus_wdata = (bus_req && isData) ? data_wdata : 32'd0;
        accept = bus_req && bus_addr_ok;
        done = !rst && bus_data_ok && (accept || state == RESP);
        inst_addr_ok = accept && !isData;
        data_addr_ok = accept && isData;
        inst_data_ok = done && !isData;
        data_data_ok = done && isData;
        inst_rdata = inst_data_ok ? bus_rdata : 32'd0;
        data_rdata = data_data_ok ? bus_rdata : 32'd0;
        nextState = done ? IDLE : accept ? RESP : bus_req ? REQ : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gntSel <= GNT_INST;
            starveCnt <= 3'd0;
        end else begin
            state <= nextState;
            if (state == IDLE && bus_req) gntSel <= winner;
            starveCnt <= (!inst_req || inst_addr_ok) ? 3'd0 :
                         (data_addr_ok && starveCnt != 3'(STARVE_MAX)) ? starveCnt + 3'd1 : starveCnt;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle-by-cycle directed vectors for mem_arbiter plus a starvation run.
module tb_mem_arbiter;
    logic clk = 0, rst = 1;
    logic inst_req = 0, data_req = 0, data_wr = 0, bus_addr_ok = 0, bus_data_ok = 0;
    logic [1:0] data_size = 0;
    logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, bus_rdata = 0;
    logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, bus_wr;
    logic [1:0] bus_size;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    int nCmp = 0, nBad = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, ir, dr, dw, aok, dok;
        logic [1:0] ds;
        logic [31:0] ia, da, dwd, rd;
        logic [135:0] exp;
    } vecT;

    vecT vecs[$];

    function automatic vecT mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw, logic [1:0] ds,
                               logic [31:0] da, logic [31:0] dwd, logic aok, logic dok, logic [31:0] rd,
                               logic breq, logic bwr, logic [1:0] bsz, logic [31:0] baddr, logic [31:0] bwd,
                               logic iaok, logic idok, logic [31:0] ird, logic daok, logic ddok, logic [31:0] drd);
        vecT v;
        v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.ds = ds; v.da = da; v.dwd = dwd;
        v.aok = aok; v.dok = dok; v.rd = rd;
        v.exp = {breq, bwr, bsz, baddr, bwd, iaok, idok, ird, daok, ddok, drd};
        return v;
    endfunction

    function automatic logic [135:0] actual();
        return {bus_req, bus_wr, bus_size, bus_addr, bus_wdata, inst_addr_ok, inst_data_ok, inst_rdata,
                data_addr_ok, data_data_ok, data_rdata};
    endfunction

    initial begin
        // reset state and reset gating
        vecs.push_back(mk(1, 0,0, 0,0,0,0,0, 0,0,0,                                  0,0,0,0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(1, 1,32'hBFC00000, 0,0,0,0,0, 1,0,0,                      0,0,0,0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,                                  0,0,0,0,0, 0,0,0, 0,0,0));
        // single fetch
        vecs.push_back(mk(0, 1,32'hBFC00000, 0,0,0,0,0, 1,0,0,                      1,0,2,32'hBFC00000,0, 1,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,32'h3C1D0001,                      0,0,0,0,0, 0,1,32'h3C1D0001, 0,0,0));
        // simultaneous: data store first, inst the cycle after data_ok
        vecs.push_back(mk(0, 1,32'hBFC00004, 1,1,2,32'h80000010,32'hDEADBEEF, 1,0,0, 1,1,2,32'h80000010,32'hDEADBEEF, 0,0,0, 1,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00004, 0,0,0,0,0, 0,1,32'h00000001,           0,0,0,0,0, 0,0,0, 0,1,32'h00000001));
        vecs.push_back(mk(0, 1,32'hBFC00004, 0,0,0,0,0, 1,0,0,                      1,0,2,32'hBFC00004,0, 1,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,32'hCAFEF00D,                      0,0,0,0,0, 0,1,32'hCAFEF00D, 0,0,0));
        // grant lock: inst waits in REQ while data_req rises
        vecs.push_back(mk(0, 1,32'hBFC00008, 0,0,0,0,0, 0,0,0,                      1,0,2,32'hBFC00008,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00008, 1,0,1,32'h80000020,0, 0,0,0,           1,0,2,32'hBFC00008,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00008, 1,0,1,32'h80000020,0, 0,0,0,           1,0,2,32'hBFC00008,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00008, 1,0,1,32'h80000020,0, 1,0,0,           1,0,2,32'hBFC00008,0, 1,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 1,0,1,32'h80000020,0, 0,1,32'h11111111,           0,0,0,0,0, 0,1,32'h11111111, 0,0,0));
        // data load enters REQ, then combined addr_ok+data_ok
        vecs.push_back(mk(0, 0,0, 1,0,1,32'h80000020,0, 0,0,0,                      1,0,1,32'h80000020,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 1,0,1,32'h80000020,0, 1,1,32'h12345678,           1,0,1,32'h80000020,0, 0,0,0, 1,1,32'h12345678));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,                                  0,0,0,0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,32'hFFFFFFFF,                      0,0,0,0,0, 0,0,0, 0,0,0));
        // starvation: 4 data grants, then inst, then data again
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(0, 1,32'hBFC00100, 1,0,2,32'h80000100,0, 1,0,0,       1,0,2,32'h80000100,0, 0,0,0, 1,0,0));
            vecs.push_back(mk(0, 1,32'hBFC00100, 1,0,2,32'h80000100,0, 0,1,32'hA,   0,0,0,0,0, 0,0,0, 0,1,32'hA));
        end
        vecs.push_back(mk(0, 1,32'hBFC00100, 1,0,2,32'h80000100,0, 1,0,0,           1,0,2,32'hBFC00100,0, 1,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00100, 1,0,2,32'h80000100,0, 0,1,32'hB,       0,0,0,0,0, 0,1,32'hB, 0,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00100, 1,0,2,32'h80000100,0, 1,0,0,           1,0,2,32'h80000100,0, 0,0,0, 1,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00100, 1,0,2,32'h80000100,0, 0,1,32'hC,       0,0,0,0,0, 0,0,0, 0,1,32'hC));
        // reset in RESP, stale data_ok afterwards
        vecs.push_back(mk(0, 1,32'hBFC00200, 0,0,0,0,0, 1,0,0,                      1,0,2,32'hBFC00200,0, 1,0,0, 0,0,0));
        vecs.push_back(mk(1, 0,0, 0,0,0,0,0, 0,1,32'hDDDDDDDD,                      0,0,0,0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,32'hDDDDDDDD,                      0,0,0,0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,0,0,                                  0,0,0,0,0, 0,0,0, 0,0,0));
        // data_ok alone in REQ is ignored
        vecs.push_back(mk(0, 1,32'hBFC00300, 0,0,0,0,0, 0,0,0,                      1,0,2,32'hBFC00300,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00300, 0,0,0,0,0, 0,1,32'hEEEEEEEE,           1,0,2,32'hBFC00300,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,32'hBFC00300, 0,0,0,0,0, 1,0,0,                      1,0,2,32'hBFC00300,0, 1,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0,0,0, 0,1,32'h0BADF00D,                      0,0,0,0,0, 0,1,32'h0BADF00D, 0,0,0));

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r; inst_req = vecs[i].ir; inst_addr = vecs[i].ia;
            data_req = vecs[i].dr; data_wr = vecs[i].dw; data_size = vecs[i].ds;
            data_addr = vecs[i].da; data_wdata = vecs[i].dwd;
            bus_addr_ok = vecs[i].aok; bus_data_ok = vecs[i].dok; bus_rdata = vecs[i].rd;
            #1;
            nCmp++;
            if (actual() !== vecs[i].exp) begin
                nBad++;
                $display("FAIL vec%0d: got %h required %h", i, actual(), vecs[i].exp);
            end
        end

        // free-running bus completing every cycle: 4 data grants between inst grants, twice
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC00400; data_req = 1; data_wr = 0; data_size = 2;
        data_addr = 32'h80000400; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h5;
        for (int k = 0; k < 2; k++) begin
            int nd = 0;
            bit got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (c > 0 || k > 0) @(negedge clk);
                #1;
                if (inst_addr_ok) got = 1;
                else if (data_addr_ok) nd++;
            end
            nCmp++;
            if (!got || nd != 4) begin
                nBad++;
                $display("FAIL starve%0d: %0d data grants before inst (inst seen=%0d), required 4", k, nd, got);
            end
        end
        @(negedge clk);
        inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
